// File: rtl/tft_draw_sched_if.sv
// tft_draw_sched_if
//   Bundles everything that crosses the scheduler boundary: the client side
//   (requests, per-client colors/rectangles, grant/ack/err, blit position) and
//   the tft_ctrl side (init/draw pulses, busy, latched rectangle, color, cursor).
//   modport slave  : used by tft_draw_sched.
//   modport master : used by whoever plays the clients and tft_ctrl.
//   NREQ must match the NREQ of the scheduler it is connected to.
interface tft_draw_sched_if #(
    parameter int NREQ = 4
);
    logic                 ready;
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   req_color;
    logic [16*NREQ-1:0]   req_xstart;
    logic [16*NREQ-1:0]   req_xend;
    logic [16*NREQ-1:0]   req_ystart;
    logic [16*NREQ-1:0]   req_yend;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic                 tft_init;
    logic                 tft_draw;
    logic                 tft_busy;
    logic [15:0]          tft_color;
    logic [15:0]          tft_xstart;
    logic [15:0]          tft_xend;
    logic [15:0]          tft_ystart;
    logic [15:0]          tft_yend;
    logic [15:0]          tft_curx;
    logic [15:0]          tft_cury;
    logic [15:0]          cur_x;
    logic [15:0]          cur_y;

    modport slave (
        input  req, req_color, req_xstart, req_xend, req_ystart, req_yend,
        input  tft_busy, tft_curx, tft_cury,
        output ready, gnt, ack, err, tft_init, tft_draw, tft_color,
        output tft_xstart, tft_xend, tft_ystart, tft_yend, cur_x, cur_y
    );

    modport master (
        output req, req_color, req_xstart, req_xend, req_ystart, req_yend,
        output tft_busy, tft_curx, tft_cury,
        input  ready, gnt, ack, err, tft_init, tft_draw, tft_color,
        input  tft_xstart, tft_xend, tft_ystart, tft_yend, cur_x, cur_y
    );
endinterface

// File: rtl/tft_draw_sched.sv
// tft_draw_sched
//   Shares one tft_ctrl between NREQ drawing clients. After reset it runs the
//   panel init sequence once, then grants draw jobs round-robin, latches the
//   winner's rectangle, forwards the winner's live color and pulses ack (with
//   err on rejection/abort) back to the client.
// Ports
//   clk   in  system clock
//   rstn  in  asynchronous active-low reset
//   bus   tft_draw_sched_if.slave: req/req_color/req_* rectangles in, gnt/ack/err
//         and ready out; tft_init/tft_draw/tft_color/tft_x*/tft_y* out to tft_ctrl,
//         tft_busy/tft_curx/tft_cury in from tft_ctrl; cur_x/cur_y out to clients.
// Configuration
//   TFT_SCHED_WDOG_EN : when defined, a WDOG_WIDTH-bit watchdog bounds every
//   wait on tft_busy. Draw waits complete with ack+err, init waits restart
//   from BOOT. When undefined the waits are unbounded.
module tft_draw_sched #(
    parameter int NREQ       = 4,
    parameter int WDOG_WIDTH = 24
) (
    input  logic             clk,
    input  logic             rstn,
    tft_draw_sched_if.slave  bus
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {
        BOOT, I_START, I_DONE, IDLE, CHECK, D_START, D_DONE, DONE
    } state_t;

    state_t            state_reg, state_next;
    logic              ready_reg, ready_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   ack_reg, ack_next;
    logic              err_reg, err_next;
    logic              init_reg, init_next;
    logic              draw_reg, draw_next;
    logic [15:0]       xs_reg, xs_next, xe_reg, xe_next;
    logic [15:0]       ys_reg, ys_next, ye_reg, ye_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic              wdog_expired;

    // Round-robin search starting just after the last winner.
    logic [PW-1:0]     win_idx;
    logic              win_found;
    logic [PW:0]       arb_idx;

    always_comb begin
        win_idx   = ptr_reg;
        win_found = 1'b0;
        arb_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            arb_idx = {1'b0, ptr_reg} + (PW+1)'(i);
            if (arb_idx >= (PW+1)'(NREQ))
                arb_idx = arb_idx - (PW+1)'(NREQ);
            if (!win_found && bus.req[arb_idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = arb_idx[PW-1:0];
            end
        end
    end

`ifdef TFT_SCHED_WDOG_EN
    logic [WDOG_WIDTH-1:0] wdog_reg;
    logic                  wdog_waiting;

    assign wdog_waiting = (state_reg == I_START) || (state_reg == I_DONE) ||
                          (state_reg == D_START) || (state_reg == D_DONE);
    assign wdog_expired = wdog_waiting && (&wdog_reg);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wdog_reg <= '0;
        else if ((state_next != state_reg) || !wdog_waiting)
            wdog_reg <= '0;
        else
            wdog_reg <= wdog_reg + 1'b1;
    end
`else
    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        ready_next = ready_reg;
        gnt_next   = gnt_reg;
        ack_next   = '0;
        err_next   = 1'b0;
        init_next  = 1'b0;
        draw_next  = 1'b0;
        xs_next    = xs_reg;
        xe_next    = xe_reg;
        ys_next    = ys_reg;
        ye_next    = ye_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            // tft_ctrl has no reset of its own: let any job in flight finish.
            BOOT: begin
                if (!bus.tft_busy) begin
                    init_next  = 1'b1;
                    state_next = I_START;
                end
            end
            I_START: begin
                if (wdog_expired)
                    state_next = BOOT;
                else if (bus.tft_busy)
                    state_next = I_DONE;
            end
            I_DONE: begin
                if (wdog_expired)
                    state_next = BOOT;
                else if (!bus.tft_busy) begin
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (win_found) begin
                    gnt_next          = '0;
                    gnt_next[win_idx] = 1'b1;
                    xs_next           = bus.req_xstart[16*win_idx +: 16];
                    xe_next           = bus.req_xend[16*win_idx +: 16];
                    ys_next           = bus.req_ystart[16*win_idx +: 16];
                    ye_next           = bus.req_yend[16*win_idx +: 16];
                    ptr_next          = win_idx;
                    state_next        = CHECK;
                end
            end
            CHECK: begin
                if ((xs_reg > xe_reg) || (ys_reg > ye_reg)) begin
                    ack_next   = gnt_reg;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    draw_next  = 1'b1;
                    state_next = D_START;
                end
            end
            D_START: begin
                if (wdog_expired) begin
                    ack_next   = gnt_reg;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else if (bus.tft_busy)
                    state_next = D_DONE;
            end
            D_DONE: begin
                if (wdog_expired) begin
                    ack_next   = gnt_reg;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else if (!bus.tft_busy) begin
                    ack_next   = gnt_reg;
                    state_next = DONE;
                end
            end
            DONE: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= BOOT;
            ready_reg <= 1'b0;
            gnt_reg   <= '0;
            ack_reg   <= '0;
            err_reg   <= 1'b0;
            init_reg  <= 1'b0;
            draw_reg  <= 1'b0;
            xs_reg    <= '0;
            xe_reg    <= '0;
            ys_reg    <= '0;
            ye_reg    <= '0;
            ptr_reg   <= PW'(NREQ - 1);
        end else begin
            state_reg <= state_next;
            ready_reg <= ready_next;
            gnt_reg   <= gnt_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            init_reg  <= init_next;
            draw_reg  <= draw_next;
            xs_reg    <= xs_next;
            xe_reg    <= xe_next;
            ys_reg    <= ys_next;
            ye_reg    <= ye_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Live color of the granted client; zero when nobody holds the grant.
    logic [15:0] color_masked [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_color
        assign color_masked[gi] = gnt_reg[gi] ? bus.req_color[16*gi +: 16] : 16'h0000;
    end

    always_comb begin
        bus.tft_color = 16'h0000;
        for (int i = 0; i < NREQ; i++)
            bus.tft_color = bus.tft_color | color_masked[i];
    end

    assign bus.ready      = ready_reg;
    assign bus.gnt        = gnt_reg;
    assign bus.ack        = ack_reg;
    assign bus.err        = err_reg;
    assign bus.tft_init   = init_reg;
    assign bus.tft_draw   = draw_reg;
    assign bus.tft_xstart = xs_reg;
    assign bus.tft_xend   = xe_reg;
    assign bus.tft_ystart = ys_reg;
    assign bus.tft_yend   = ye_reg;
    assign bus.cur_x      = bus.tft_curx;
    assign bus.cur_y      = bus.tft_cury;
endmodule

// File: tb/tb_tft_draw_sched.sv
// tb_tft_draw_sched
//   Self-checking bench for tft_draw_sched with NREQ=4. Plays all four clients
//   and a behavioural tft_ctrl (busy rises a few cycles after init/draw, stays
//   high for a programmable time, can be held stuck). Single jobs come from a
//   vector table; held requests, live color tracking and a stuck busy are
//   written out as sequences.
module tb_tft_draw_sched;
    localparam int NREQ = 4;
`ifdef TFT_SCHED_WDOG_EN
    localparam int INIT_BUSY = 40;
`else
    localparam int INIT_BUSY = 100;
`endif
    localparam int DRAW_BUSY = 8;

    logic clk;
    logic rstn;

    tft_draw_sched_if #(.NREQ(NREQ)) bus ();

    tft_draw_sched #(.NREQ(NREQ), .WDOG_WIDTH(6)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int init_cnt = 0;
    int draw_cnt = 0;
    int gnt_viol = 0;
    int nr_viol = 0;
    int busy_delay = 5;
    int busy_len = INIT_BUSY;
    logic stuck = 1'b0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [15:0] xs, xe, ys, ye;
        logic        err;
        int          draws;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Behavioural tft_ctrl.
    initial begin
        bus.tft_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tft_init || bus.tft_draw) begin
                repeat (busy_delay) @(negedge clk);
                bus.tft_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                while (stuck) @(negedge clk);
                bus.tft_busy = 1'b0;
            end
        end
    end

    // Pulse counters and grant invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tft_init) init_cnt++;
            if (bus.tft_draw) draw_cnt++;
            if (!$onehot0(bus.gnt)) gnt_viol++;
            if (!bus.ready && (bus.gnt != 4'b0000)) nr_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic load_rect(input int c, input logic [15:0] xs, input logic [15:0] xe,
                             input logic [15:0] ys, input logic [15:0] ye);
        bus.req_xstart[16*c +: 16] = xs;
        bus.req_xend[16*c +: 16]   = xe;
        bus.req_ystart[16*c +: 16] = ys;
        bus.req_yend[16*c +: 16]   = ye;
    endtask

    task automatic do_reset();
        int cyc;
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_ack_err", 64'({bus.ack, bus.err}), 64'd0);
        chk("rst_pulses", 64'({bus.tft_init, bus.tft_draw}), 64'd0);
        chk("rst_rect", {bus.tft_xstart, bus.tft_xend, bus.tft_ystart, bus.tft_yend}, 64'd0);
        chk("rst_color", 64'(bus.tft_color), 64'd0);
        busy_len = INIT_BUSY;
        init_cnt = 0;
        rstn = 1'b1;
        cyc = 0;
        while (!bus.ready && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("init_ready", 64'(bus.ready), 64'd1);
        chk("init_pulses", 64'(init_cnt), 64'd1);
        chk("init_busy_low", 64'(bus.tft_busy), 64'd0);
        chk("init_after_busy", 64'(cyc > INIT_BUSY), 64'd1);
        $display("reset: ready after %0d cycles, %0d init pulse(s)", cyc, init_cnt);
        busy_len = DRAW_BUSY;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int cyc;
        int d0;
        for (int c = 0; c < NREQ; c++) begin
            if (v.gnt[c])
                load_rect(c, v.xs, v.xe, v.ys, v.ye);
            else
                load_rect(c, 16'h0F00 + 16'(c), 16'h0F10 + 16'(c), 16'h0F20 + 16'(c), 16'h0F30 + 16'(c));
        end
        d0 = draw_cnt;
        bus.req = v.req;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.gnt == 4'b0000 && cyc < 20);
        chk("vec_gnt", 64'(bus.gnt), 64'(v.gnt));
        chk("vec_gnt_lat", 64'(cyc), 64'd1);
        chk("vec_rect", {bus.tft_xstart, bus.tft_xend, bus.tft_ystart, bus.tft_yend},
            {v.xs, v.xe, v.ys, v.ye});
        // Drop the request and scribble over coordinates: the job must carry on unchanged.
        bus.req = 4'b0000;
        for (int c = 0; c < NREQ; c++) load_rect(c, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
        cyc = 0;
        while (bus.ack == 4'b0000 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("vec_ack", 64'(bus.ack), 64'(v.gnt));
        chk("vec_err", 64'(bus.err), 64'(v.err));
        chk("vec_rect_hold", {bus.tft_xstart, bus.tft_xend, bus.tft_ystart, bus.tft_yend},
            {v.xs, v.xe, v.ys, v.ye});
        chk("vec_draws", 64'(draw_cnt - d0), 64'(v.draws));
        if (v.err) chk("vec_reject_lat", 64'(cyc), 64'd1);
        $display("vec %0d: req=%b gnt=%b ack=%b err=%b draws=%0d", n, v.req, v.gnt, bus.ack,
                 bus.err, draw_cnt - d0);
        repeat (3) tick();
        chk("vec_idle_gnt", 64'(bus.gnt), 64'd0);
    endtask

    initial begin
        int cyc;
        int acks;
        logic [15:0] val;

        rstn = 1'b0;
        bus.req = '0;
        bus.req_color = '0;
        bus.req_xstart = '0;
        bus.req_xend = '0;
        bus.req_ystart = '0;
        bus.req_yend = '0;
        bus.tft_curx = '0;
        bus.tft_cury = '0;

        //          req      gnt      xs      xe      ys      ye      err  draws
        vecs[0] = '{4'b0001, 4'b0001, 16'd10, 16'd12, 16'd20, 16'd21, 1'b0, 1};
        vecs[1] = '{4'b0010, 4'b0010, 16'd50, 16'd49, 16'd0,  16'd5,  1'b1, 0};
        vecs[2] = '{4'b0100, 4'b0100, 16'd7,  16'd7,  16'd7,  16'd7,  1'b0, 1};
        vecs[3] = '{4'b1000, 4'b1000, 16'd0,  16'd3,  16'd9,  16'd8,  1'b1, 0};
        vecs[4] = '{4'b0110, 4'b0010, 16'd100, 16'd199, 16'd40, 16'd40, 1'b0, 1};
        vecs[5] = '{4'b1001, 4'b1000, 16'd0,  16'd0,  16'd0,  16'd0,  1'b0, 1};
        vecs[6] = '{4'b1001, 4'b0001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1};
        vecs[7] = '{4'b1100, 4'b0100, 16'd5,  16'd4,  16'd5,  16'd4,  1'b1, 0};
        vecs[8] = '{4'b1011, 4'b1000, 16'd1,  16'd2,  16'd3,  16'd4,  1'b0, 1};

        // Init sequence.
        do_reset();

        // Single jobs, arbitration from a moving pointer, rejection.
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // All clients held high across a reset: nothing granted before ready,
        // then strict rotation starting at client 0.
        for (int c = 0; c < NREQ; c++) load_rect(c, 16'(c), 16'(c + 1), 16'd0, 16'd1);
        bus.req = 4'b1111;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (bus.ack == 4'b0000 && cyc < 100);
            chk("rr_ack", 64'(bus.ack), 64'(4'b0001 << (k % 4)));
            chk("rr_err", 64'(bus.err), 64'd0);
            $display("rr job %0d: ack=%b err=%b", k, bus.ack, bus.err);
        end
        bus.req = 4'b0000;
        repeat (3) tick();
        chk("rr_idle_gnt", 64'(bus.gnt), 64'd0);

        // Live color and cursor pass-through while client 1 holds the grant.
        for (int c = 0; c < NREQ; c++) begin
            load_rect(c, 16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03);
            bus.req_color[16*c +: 16] = 16'hAAAA;
        end
        load_rect(1, 16'd30, 16'd40, 16'd50, 16'd60);
        bus.req = 4'b0010;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.gnt == 4'b0000 && cyc < 20);
        chk("col_gnt", 64'(bus.gnt), 64'(4'b0010));
        bus.req = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            val = 16'h1234 + 16'(k) * 16'h1111;
            bus.req_color[31:16] = val;
            bus.tft_curx = 16'(3 * k + 1);
            bus.tft_cury = 16'(200 - k);
            load_rect(1, 16'h7777, 16'h7777, 16'h7777, 16'h7777);
            #1;
            chk("col_track", 64'(bus.tft_color), 64'(val));
            chk("col_cur", 64'({bus.cur_x, bus.cur_y}), 64'({16'(3 * k + 1), 16'(200 - k)}));
            chk("col_rect", {bus.tft_xstart, bus.tft_xend, bus.tft_ystart, bus.tft_yend},
                {16'd30, 16'd40, 16'd50, 16'd60});
            $display("color step %0d: tft_color=%h cur_x=%0d", k, bus.tft_color, bus.cur_x);
            tick();
        end
        cyc = 0;
        while (bus.ack == 4'b0000 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("col_ack", 64'({bus.ack, bus.err}), 64'({4'b0010, 1'b0}));
        repeat (3) tick();
        chk("col_idle_color", 64'(bus.tft_color), 64'd0);

        // tft_ctrl busy stuck high during a draw.
        load_rect(0, 16'd1, 16'd2, 16'd1, 16'd2);
        stuck = 1'b1;
        bus.req = 4'b0001;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.gnt == 4'b0000 && cyc < 20);
        chk("stk_gnt", 64'(bus.gnt), 64'(4'b0001));
        bus.req = 4'b0000;
`ifdef TFT_SCHED_WDOG_EN
        cyc = 0;
        while (bus.ack == 4'b0000 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("stk_wdog_ack", 64'({bus.ack, bus.err}), 64'({4'b0001, 1'b1}));
        chk("stk_wdog_time", 64'(cyc >= 63), 64'd1);
        $display("stuck job: watchdog ack=%b err=%b after %0d cycles", bus.ack, bus.err, cyc);
        repeat (3) tick();
        chk("stk_wdog_idle", 64'(bus.gnt), 64'd0);
        stuck = 1'b0;
        repeat (5) tick();
`else
        acks = 0;
        repeat (150) begin
            tick();
            if (bus.ack != 4'b0000) acks++;
        end
        chk("stk_no_ack", 64'(acks), 64'd0);
        chk("stk_gnt_held", 64'(bus.gnt), 64'(4'b0001));
        stuck = 1'b0;
        cyc = 0;
        while (bus.ack == 4'b0000 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("stk_release_ack", 64'({bus.ack, bus.err}), 64'({4'b0001, 1'b0}));
        $display("stuck job: held %0d cycles, ack=%b err=%b after release", 150, bus.ack, bus.err);
`endif

        chk("onehot_gnt", 64'(gnt_viol), 64'd0);
        chk("no_gnt_before_ready", 64'(nr_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
